// File: rtl/brake_oil_pkg.sv
// brake_oil_pkg: shared FSM states and constants for the brake-oil level acquisition path
package brake_oil_pkg;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE} state_t;
    localparam int LEVEL_W = 8;
    localparam logic [LEVEL_W-1:0] OPEN_WIRE_CODE = 8'hFF;
    localparam logic [1:0] FAULT_COUNT = 2'd3;
endpackage

// File: rtl/brake_oil_avg4.sv
// brake_oil_avg4: 4-sample mean (3 stored + incoming), preloaded on load_first; ports clock, reset, load_first, push, sample -> avg
module brake_oil_avg4 import brake_oil_pkg::*; (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_first,
    input  logic               push,
    input  logic [LEVEL_W-1:0] sample,
    output logic [LEVEL_W-1:0] avg
);
    logic [LEVEL_W-1:0] h0, h1, h2;
    logic [LEVEL_W+1:0] sum;
    assign sum = {2'b0, sample} + {2'b0, h0} + {2'b0, h1} + {2'b0, h2};
    assign avg = load_first ? sample : sum[LEVEL_W+1:2];
    always_ff @(posedge clock) begin
        if (reset) begin
            h0 <= '0;
            h1 <= '0;
            h2 <= '0;
        end else if (load_first) begin
            h0 <= sample;
            h1 <= sample;
            h2 <= sample;
        end else if (push) begin
            h0 <= sample;
            h1 <= h0;
            h2 <= h1;
        end
    end
endmodule

// File: rtl/brake_oil_sensor.sv
// brake_oil_sensor: serial ADC reader -> open-wire screened break_oil level (clock, reset, adc_sdo in; adc_cs_n, adc_sclk, break_oil, level_valid, sensor_fault out); BRAKE_OIL_FILTER_EN adds 4-sample mean
module brake_oil_sensor import brake_oil_pkg::*; #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               adc_sdo,
    output logic               adc_cs_n,
    output logic               adc_sclk,
    output logic [LEVEL_W-1:0] break_oil,
    output logic               level_valid,
    output logic               sensor_fault
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int TW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      timer;
    logic [2:0]         bit_cnt;
    logic [LEVEL_W-1:0] raw, level;
    logic [1:0]         ff_cnt;
    logic               good_update;
    assign good_update = state == UPDATE && raw != OPEN_WIRE_CODE;
`ifdef BRAKE_OIL_FILTER_EN
    logic primed;
    always_ff @(posedge clock) primed <= reset ? 1'b0 : primed | good_update;
    brake_oil_avg4 u_avg4 (
        .clock      (clock),
        .reset      (reset),
        .load_first (good_update && !primed),
        .push       (good_update),
        .sample     (raw),
        .avg        (level)
    );
`else
    assign level = raw;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            timer        <= '0;
            bit_cnt      <= '0;
            raw          <= '0;
            ff_cnt       <= '0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b0;
            break_oil    <= '0;
            level_valid  <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            timer       <= timer != '0 ? timer - TW'(1) : state == IDLE ? TW'(SAMPLE_PERIOD - 1) : timer;
            cnt         <= cnt != '0 ? cnt - CW'(1) : DIV_LOAD;
            case (state)
                IDLE: if (timer == '0) begin
                    state    <= CS_SETUP;
                    adc_cs_n <= 1'b0;
                    cnt      <= DIV_LOAD;
                end
                CS_SETUP: if (cnt == '0) begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                end
                SHIFT: if (cnt == '0) begin
                    adc_sclk <= !adc_sclk;
                    if (!adc_sclk) raw <= {raw[LEVEL_W-2:0], adc_sdo};
                    else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= CS_HOLD;
                    end
                end
                CS_HOLD: if (cnt == '0) begin
                    adc_cs_n <= 1'b1;
                    state    <= UPDATE;
                end
                UPDATE: begin
                    state <= IDLE;
                    if (raw == OPEN_WIRE_CODE) begin
                        ff_cnt <= ff_cnt == FAULT_COUNT ? ff_cnt : ff_cnt + 2'd1;
                        if (ff_cnt >= FAULT_COUNT - 2'd1) sensor_fault <= 1'b1;
                    end else begin
                        ff_cnt       <= '0;
                        sensor_fault <= 1'b0;
                        break_oil    <= level;
                        level_valid  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_brake_oil_sensor.sv
// tb_brake_oil_sensor: randomized self-checking bench against a queue-based level model
module tb_brake_oil_sensor;
    localparam int CD  = 4;
    localparam int SP  = 100;
    localparam int LAT = 18 * CD + 1;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       adc_sdo, adc_cs_n, adc_sclk, level_valid, sensor_fault;
    logic [7:0] break_oil;
    logic [7:0] adc_word = 8'h00;
    int         nrise = 0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         ffc = 0;
    int         last_start = -1;
    logic       exp_fault = 1'b0;
    logic [7:0] exp_level = 8'h00;
    logic [7:0] hist[$];

    brake_oil_sensor #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
        .clock        (clock),
        .reset        (reset),
        .adc_sdo      (adc_sdo),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .break_oil    (break_oil),
        .level_valid  (level_valid),
        .sensor_fault (sensor_fault)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(posedge adc_sclk or negedge adc_cs_n) nrise <= adc_sclk ? nrise + 1 : 0;
    assign adc_sdo = nrise < 8 ? adc_word[3'(7 - nrise)] : 1'b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_push(input logic [7:0] w);
        int s = 0;
`ifdef BRAKE_OIL_FILTER_EN
        if (hist.size() == 0) repeat (4) hist.push_back(w);
        else begin
            hist.push_back(w);
            void'(hist.pop_front());
        end
        foreach (hist[i]) s += int'(hist[i]);
        return 8'(s / 4);
`else
        s = int'(w);
        return 8'(s);
`endif
    endfunction

    task automatic model_reset();
        ffc = 0;
        exp_fault = 1'b0;
        exp_level = 8'h00;
        hist.delete();
        last_start = -1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (adc_cs_n === 1'b1 && n < 2 * SP) begin
            @(negedge clock);
            n++;
        end
        check("start_timeout", 32'(adc_cs_n), 32'(0));
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(negedge clock);
        check({tag, "_rst_cs_n"}, 32'(adc_cs_n), 32'(1));
        check({tag, "_rst_sclk"}, 32'(adc_sclk), 32'(0));
        check({tag, "_rst_level"}, 32'(break_oil), 32'(0));
        check({tag, "_rst_valid"}, 32'(level_valid), 32'(0));
        check({tag, "_rst_fault"}, 32'(sensor_fault), 32'(0));
        repeat (2) @(negedge clock);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic conv(input logic [7:0] w, input string tag, input int exp_wait);
        int   n;
        int   pulses = 0;
        logic exp_lv;
        adc_word = w;
        wait_start(n);
        if (exp_wait >= 0) check({tag, "_start_delay"}, 32'(n), 32'(exp_wait));
        if (last_start >= 0) check({tag, "_period"}, 32'(cyc - last_start), 32'(SP));
        last_start = cyc;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clock);
            if (k < LAT) pulses += int'(level_valid);
            if (k == LAT - 1) check({tag, "_hold"}, 32'(break_oil), 32'(exp_level));
        end
        if (w != 8'hFF) begin
            ffc = 0;
            exp_fault = 1'b0;
            exp_level = model_push(w);
            exp_lv = 1'b1;
        end else begin
            ffc = ffc < 3 ? ffc + 1 : 3;
            if (ffc == 3) exp_fault = 1'b1;
            exp_lv = 1'b0;
        end
        check({tag, "_early_pulse"}, 32'(pulses), 32'(0));
        check({tag, "_sclk_pulses"}, 32'(nrise), 32'(8));
        check({tag, "_valid"}, 32'(level_valid), 32'(exp_lv));
        check({tag, "_level"}, 32'(break_oil), 32'(exp_level));
        check({tag, "_fault"}, 32'(sensor_fault), 32'(exp_fault));
        @(negedge clock);
        check({tag, "_pulse_end"}, 32'(level_valid), 32'(0));
    endtask

    task automatic reset_at(input int k_at, input logic sclk_exp, input string tag);
        int n;
        adc_word = 8'($urandom_range(0, 254));
        wait_start(n);
        repeat (k_at) @(negedge clock);
        check({tag, "_pre_sclk"}, 32'(adc_sclk), 32'(sclk_exp));
        check({tag, "_pre_valid"}, 32'(level_valid), 32'(0));
        do_reset(tag);
        conv(8'($urandom_range(0, 254)), {tag, "_fresh"}, 1);
    endtask

    initial begin
        do_reset("init");
        conv(8'h40, "first", 1);
        conv(8'h05, "low", -1);
        check("low_threshold", 32'(break_oil < 8'd10), 32'(1));
        conv(8'hC8, "high", -1);
        conv(8'h80, "good", -1);
        conv(8'hFF, "ff1", -1);
        conv(8'hFF, "ff2", -1);
        conv(8'hFF, "ff3", -1);
        conv(8'hFF, "ff4", -1);
        conv(8'h30, "recover", -1);
        reset_at(33, 1'b1, "mid_shift");
        reset_at(LAT - 1, 1'b0, "in_update");
        do_reset("filt");
        conv(8'd100, "f1", 1);
        conv(8'd100, "f2", -1);
        conv(8'hFF, "f_ff", -1);
        conv(8'd100, "f3", -1);
        conv(8'd104, "f4", -1);
        for (int i = 0; i < 16; i++)
            conv($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom_range(0, 255)), $sformatf("rnd%0d", i), -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/brake_oil_sensor.md
# brake_oil_sensor

Acquisition front end for the brake-oil level path. It periodically reads an 8-bit serial ADC attached to the reservoir level sensor and deserialises the result. It filters the value, screens it for open-wire faults, and presents it as the 8-bit `break_oil` level consumed by the dashboard warning logic. It is the producer end of the `break_oil` bus: the level bus it drives is what the low-oil warning FSM compares against its threshold.

## Interface

Parameters:
- `CLK_DIV`, 4: `adc_sclk` half-period in `clock` cycles; must be ≥ 1.
- `SAMPLE_PERIOD`, 1000: `clock` cycles from one conversion start to the next; must be ≥ 18*CLK_DIV+2.

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `adc_sdo`  in  1  ADC serial data, MSB first.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock, idle low.
- `break_oil`  out  8  current oil level, 0 = empty, 255 = full scale.
- `level_valid`  out  1  one-cycle pulse when `break_oil` takes a new value.
- `sensor_fault`  out  1  open-wire fault flag.

## Operation

- FSM states and transitions:
  - IDLE → CS_SETUP when the sample timer expires.
  - CS_SETUP lasts CLK_DIV cycles, with `adc_cs_n`=0 and `adc_sclk`=0, then → SHIFT.
  - SHIFT runs 8 bits.
    - Each bit is sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
    - `adc_sdo` is captured on the clock edge that drives `adc_sclk` 0→1.
    - Capture is MSB first into an 8-bit shift register.
  - SHIFT → CS_HOLD after the 8th high phase.
  - CS_HOLD lasts CLK_DIV cycles with `adc_sclk`=0, then `adc_cs_n`=1 and → UPDATE.
  - UPDATE lasts 1 cycle and evaluates the raw sample, then → IDLE.
- Open-wire screening (raw == 8'hFF):
  - The sample never updates `break_oil`, and `level_valid` does not pulse.
  - It increments a saturating 2-bit consecutive-FF counter.
  - `sensor_fault` sets in the UPDATE cycle where the counter reaches 3.
- Any raw sample ≠ 8'hFF:
  - Clears the counter and `sensor_fault`.
  - Updates `break_oil` (raw or filtered, see Configuration).
  - Pulses `level_valid`.
- While in fault, `break_oil` holds its last good value.

## Timing

- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=0.
  - `break_oil`=8'd0, so the warning path fails safe to "low oil" until the first good read.
  - `level_valid`=0, `sensor_fault`=0.
  - FSM=IDLE, sample timer=0, FF counter=0.
- The first conversion starts (CS_SETUP entered) on the first clock after `reset` deasserts. Subsequent conversions start every SAMPLE_PERIOD cycles, start to start.
- Conversion latency:
  - From CS_SETUP entry to `break_oil`/`level_valid` update is 18*CLK_DIV+1 cycles.
  - With CLK_DIV=4 that is 73 cycles.
- `break_oil` and `level_valid` change in the same cycle, and are registered outputs.
- Reset mid-conversion:
  - `adc_cs_n` returns to 1 and `adc_sclk` to 0 on the reset edge.
  - The partial sample is discarded.
  - No `level_valid` pulse is issued.
- Reset asserted in the UPDATE cycle: reset wins, and `break_oil` goes to 0.

## Configuration

- `BRAKE_OIL_FILTER_EN` defined:
  - `break_oil` is the mean of the last 4 good samples: a 10-bit sum, right-shifted by 2, truncating.
  - The history is preloaded with the first good sample after reset, so the first output equals that sample.
  - FF samples are not entered into the history.
- `BRAKE_OIL_FILTER_EN` undefined:
  - `break_oil` is the raw good sample.
  - No history registers are built.
- Latency is identical in both builds.

## Structure

- Package `brake_oil_pkg` holds:
  - the FSM state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE);
  - `OPEN_WIRE_CODE` = 8'hFF;
  - `FAULT_COUNT` = 3;
  - `LEVEL_W` = 8.
- Sub-module `brake_oil_avg4` is the 4-deep history and averager. It is instantiated only under `BRAKE_OIL_FILTER_EN`, and has inputs clock, reset, load_first, push, sample[7:0] and output avg[7:0].

## Test plan

- Reset, then the ADC model returns 8'h40:
  - `adc_cs_n` falls 1 cycle after reset release.
  - Exactly 8 sclk pulses occur.
  - `break_oil`=8'h40 with `level_valid` pulsing 73 cycles after CS_SETUP entry (CLK_DIV=4).
- Successive samples 8'h05 then 8'hC8:
  - `break_oil`=5, then 200, with one `level_valid` each, SAMPLE_PERIOD apart.
  - Checks that the downstream threshold crossing at <10 is observable.
- Three consecutive 8'hFF after a good 8'h80:
  - `break_oil` stays 8'h80 with no `level_valid`.
  - `sensor_fault` rises at the 3rd UPDATE.
  - The next 8'h30 clears the fault and gives `break_oil`=8'h30.
- Reset asserted during the 4th SHIFT bit:
  - `adc_cs_n`=1, `adc_sclk`=0, `break_oil`=0 next cycle.
  - No `level_valid`.
  - A fresh conversion starts after release.
- With `BRAKE_OIL_FILTER_EN`, samples 100, 100, 100, 104 → outputs 100, 100, 100, 101.
  - An interleaved 8'hFF leaves the average unchanged.
